// File: rtl/rv32i_mtimer.sv
// rv32i_mtimer: 48-bit machine timer with a programmable prescaler, a
// memory-mapped register window, a low-word-read shadow that makes 48-bit
// reads coherent, and the MTIP level consumed by the CSR file.
//
// Bus handshake: a request is taken on a clk edge where bus_valid=1 and
// bus_ready=0. bus_ready is then high for exactly one cycle, and bus_rdata
// is valid only in that cycle (it reads 0 for writes and at all other times).
// The master holds the request until it sees ready. A request that is still
// presented in the ready cycle is taken on the following edge.
module rv32i_mtimer #(
    parameter int unsigned TICK_DIV   = 10,
    parameter int unsigned TICK_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic [47:0] mtime,
    output logic        timer_interrupt
);

    localparam logic [1:0] REG_MTIME_LO = 2'd0;
    localparam logic [1:0] REG_MTIME_HI = 2'd1;
    localparam logic [1:0] REG_CMP_LO   = 2'd2;
    localparam logic [1:0] REG_CMP_HI   = 2'd3;

    localparam logic [TICK_CNT_W-1:0] PRESC_LAST = TICK_CNT_W'(TICK_DIV - 1);
    localparam logic [TICK_CNT_W-1:0] PRESC_ONE  = TICK_CNT_W'(1);

    logic [TICK_CNT_W-1:0] presc_q,  presc_d;
    logic [47:0]           mtime_q,  mtime_d;
    logic [47:0]           cmp_q,    cmp_d;
    logic [15:0]           shadow_q, shadow_d;
    logic [31:0]           rdata_q,  rdata_d;
    logic                  ready_q,  ready_d;
    logic                  irq_q,    irq_d;

    logic       accept;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] word_sel;
    logic       unused_addr_lsbs;

    // Byte-lane bits of the offset carry no meaning in this word-only window.
    assign unused_addr_lsbs = ^bus_addr[1:0];

    assign accept   = bus_valid && !ready_q;
    assign wr_en    = accept && bus_we;
    assign rd_en    = accept && !bus_we;
    assign word_sel = bus_addr[3:2];

    // Prescaler and mtime: a software write to either mtime half wins over
    // the tick on the same edge and restarts the prescaler from 0.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        mtime_d = mtime_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            mtime_d = mtime_q + 48'd1;
        end
        if (wr_en && (word_sel == REG_MTIME_LO)) begin
            presc_d = '0;
            mtime_d = {mtime_q[47:32], bus_wdata};
        end else if (wr_en && (word_sel == REG_MTIME_HI)) begin
            presc_d = '0;
            mtime_d = {bus_wdata[15:0], mtime_q[31:0]};
        end
    end

    // Compare register, read shadow and the registered read response.
    always_comb begin
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        rdata_d  = 32'd0;
        ready_d  = accept;
        irq_d    = (mtime_q >= cmp_q);
        if (wr_en) begin
            case (word_sel)
                REG_MTIME_HI: shadow_d = bus_wdata[15:0];
                REG_CMP_LO:   cmp_d    = {cmp_q[47:32], bus_wdata};
                REG_CMP_HI:   cmp_d    = {bus_wdata[15:0], cmp_q[31:0]};
                default:      cmp_d    = cmp_q;
            endcase
        end
        if (rd_en) begin
            case (word_sel)
                REG_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[47:32];
                end
                REG_MTIME_HI: rdata_d = {16'd0, shadow_q};
                REG_CMP_LO:   rdata_d = cmp_q[31:0];
                default:      rdata_d = {16'd0, cmp_q[47:32]};
            endcase
        end
    end

    // State registers; reset discards any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            mtime_q  <= 48'd0;
            cmp_q    <= 48'hFFFF_FFFF_FFFF;
            shadow_q <= 16'd0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            irq_q    <= irq_d;
        end
    end

    assign bus_rdata       = rdata_q;
    assign bus_ready       = ready_q;
    assign mtime           = mtime_q;
    assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// tb_rv32i_mtimer: directed bench for rv32i_mtimer. Two instances run side
// by side: TICK_DIV=10 (prescaler tests) and TICK_DIV=1 (interrupt tests).
// Bus read/write responses go through an expected-value queue checked by a
// monitor on every ready pulse; mtime/interrupt levels are checked directly.
module tb_rv32i_mtimer;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        bus_valid;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;

    logic        valid10, valid1;
    logic [31:0] rdata10, rdata1;
    logic        rdy10, rdy1;
    logic [47:0] mtime10, mtime1;
    logic        irq10, irq1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    assign valid10 = bus_valid && !sel;
    assign valid1  = bus_valid && sel;

    rv32i_mtimer #(.TICK_DIV(10), .TICK_CNT_W(16)) dut10 (
        .clk(clk), .rst_n(rst_n), .bus_valid(valid10), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata10),
        .bus_ready(rdy10), .mtime(mtime10), .timer_interrupt(irq10)
    );

    rv32i_mtimer #(.TICK_DIV(1), .TICK_CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus_valid(valid1), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata1),
        .bus_ready(rdy1), .mtime(mtime1), .timer_interrupt(irq1)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: one access to instance s (0: TICK_DIV=10, 1: TICK_DIV=1).
    // Returns on the falling edge where the ready pulse is visible.
    task automatic bus_access(input bit s, input bit we, input logic [3:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input string name);
        bit got;
        @(negedge clk);
        sel       = s;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = wd;
        exp_q.push_back(exp_rd);
        name_q.push_back(name);
        bus_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ((s ? rdy1 : rdy10) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready within 4 cycles", name);
        end
    endtask

    // Scoreboard monitor: every ready pulse consumes one expected response.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] act;
        string       n;
        if (rdy10 === 1'b1 || rdy1 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got ready=%b/%b expected none", rdy10, rdy1);
            end else begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                act = (rdy1 === 1'b1) ? rdata1 : rdata10;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got rdata %h expected %h", n, act, e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mtime10", {16'd0, mtime10}, 64'd0);
        chk("rst_mtime1", {16'd0, mtime1}, 64'd0);
        chk("rst_irq", {62'd0, irq10, irq1}, 64'd0);
        chk("rst_ready", {62'd0, rdy10, rdy1}, 64'd0);
        chk("rst_rdata", {rdata10, rdata1}, 64'd0);
        rst_n = 1'b1;

        // Idle count with TICK_DIV=10
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 9)  chk("idle_mtime_9", {16'd0, mtime10}, 64'd0);
            if (k == 10) chk("idle_mtime_10", {16'd0, mtime10}, 64'd1);
            if (k == 50) chk("idle_mtime_50", {16'd0, mtime10}, 64'd5);
            chk("idle_irq", {63'd0, irq10}, 64'd0);
            chk("idle_ready", {63'd0, rdy10}, 64'd0);
        end

        // Reset values through the bus
        bus_access(0, 0, 4'h8, 32'd0, 32'hFFFF_FFFF, "rd_cmp_lo_rst");
        bus_access(0, 0, 4'hC, 32'd0, 32'h0000_FFFF, "rd_cmp_hi_rst");
        bus_access(0, 0, 4'h4, 32'd0, 32'h0000_0000, "rd_shadow_rst");

        // mtime write and prescaler restart
        bus_access(0, 1, 4'h0, 32'hFFFF_FFFE, 32'd0, "wr_mtime_lo");
        bus_access(0, 1, 4'h4, 32'h0000_0001, 32'd0, "wr_mtime_hi");
        chk("mtime_after_wr", {16'd0, mtime10}, 64'h0001_FFFF_FFFE);
        repeat (19) @(negedge clk);
        chk("mtime_wr_plus19", {16'd0, mtime10}, 64'h0001_FFFF_FFFF);
        @(negedge clk);
        chk("mtime_wr_plus20", {16'd0, mtime10}, 64'h0002_0000_0000);

        // Coherent read across the low-to-high carry
        bus_access(0, 1, 4'h0, 32'hFFFF_FFF0, 32'd0, "wr_lo_fff0");
        bus_access(0, 1, 4'h4, 32'h0000_0000, 32'd0, "wr_hi_0");
        repeat (153) @(negedge clk);
        bus_access(0, 0, 4'h0, 32'd0, 32'hFFFF_FFFF, "rd_lo_window");
        repeat (8) @(negedge clk);
        chk("mtime_after_carry", {16'd0, mtime10}, 64'h0001_0000_0000);
        bus_access(0, 0, 4'h4, 32'd0, 32'h0000_0000, "rd_hi_shadow");

        // HI write ignores upper bits and updates the shadow
        bus_access(0, 1, 4'h4, 32'hABCD_1234, 32'd0, "wr_hi_abcd");
        bus_access(0, 0, 4'h4, 32'd0, 32'h0000_1234, "rd_hi_1234");

        // Back-to-back reads with valid held high
        @(negedge clk);
        sel      = 1'b0;
        bus_we   = 1'b0;
        bus_addr = 4'hC;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0000_FFFF);
            name_q.push_back("b2b_rd_cmp_hi");
        end
        bus_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b2b_ready", {63'd0, rdy10}, (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        bus_valid = 1'b0;

        // Interrupt rise/fall with TICK_DIV=1
        bus_access(1, 1, 4'h0, 32'd0, 32'd0, "t1_wr_mtime_lo0");
        bus_access(1, 1, 4'hC, 32'd0, 32'd0, "t1_wr_cmp_hi0");
        bus_access(1, 1, 4'h8, 32'd100, 32'd0, "t1_wr_cmp_lo100");
        bus_access(1, 1, 4'h0, 32'd95, 32'd0, "t1_wr_mtime_95");
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("irq_mtime_100", {16'd0, mtime1}, 64'd100);
                chk("irq_before_rise", {63'd0, irq1}, 64'd0);
            end
            if (k == 6) chk("irq_rise", {63'd0, irq1}, 64'd1);
        end
        bus_access(1, 1, 4'h8, 32'hFFFF_FFFF, 32'd0, "t1_wr_cmp_lo_ff");
        chk("irq_in_ready_cycle", {63'd0, irq1}, 64'd1);
        @(negedge clk);
        chk("irq_fall_after_cmp", {63'd0, irq1}, 64'd0);

        // mtime wrap with mtimecmp all-ones
        bus_access(1, 1, 4'hC, 32'h0000_FFFF, 32'd0, "t1_wr_cmp_hi_ff");
        bus_access(1, 1, 4'h4, 32'hFFFF_FFFF, 32'd0, "t1_wr_mtime_hi_ff");
        bus_access(1, 1, 4'h0, 32'hFFFF_FFFF, 32'd0, "t1_wr_mtime_lo_ff");
        chk("wrap_mtime_max", {16'd0, mtime1}, 64'h0000_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_mtime_zero", {16'd0, mtime1}, 64'd0);
        chk("wrap_irq_high", {63'd0, irq1}, 64'd1);
        @(negedge clk);
        chk("wrap_irq_fall", {63'd0, irq1}, 64'd0);
        chk("wrap_mtime_one", {16'd0, mtime1}, 64'd1);

        // Reset during a pending read
        @(negedge clk);
        sel       = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h8;
        bus_valid = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", {62'd0, rdy10, rdy1}, 64'd0);
        chk("rstmid_rdata", {rdata10, rdata1}, 64'd0);
        chk("rstmid_mtime10", {16'd0, mtime10}, 64'd0);
        chk("rstmid_mtime1", {16'd0, mtime1}, 64'd0);
        chk("rstmid_irq", {62'd0, irq10, irq1}, 64'd0);
        bus_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", {62'd0, rdy10, rdy1}, 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
